model_matrix_controller_update: RTL and testbench

Weight-update stage directly downstream of the controller differentiation block in the trainer. It consumes one gradient matrix stream (dW, dK or dU, or db as a 1×L matrix) together with the matching current-weight stream. For each element it produces the updated weight W' = W − η·dW in signed fixed point, saturating on overflow. One instance is reused per parameter matrix; the trainer sequences it with START/READY.

---
 rtl/model_trainer_pkg.sv | 21 ++
 rtl/model_scalar_gradient_step.sv | 42 ++++
 rtl/model_matrix_controller_update.sv | 91 +++++++++
 tb/tb_model_matrix_controller_update.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/model_trainer_pkg.sv
// Shared trainer constants: data/control widths, FSM encodings and saturation bounds.
package model_trainer_pkg;

  localparam int unsigned DATA_SIZE    = 64;
  localparam int unsigned CONTROL_SIZE = 64;
  localparam int unsigned FRACT_SIZE   = 32;

  typedef enum logic {
    STARTER_STATE = 1'b0,
    UPDATE_STATE  = 1'b1
  } update_state_t;

  localparam logic [DATA_SIZE-1:0]    ZERO_DATA    = '0;
  localparam logic [DATA_SIZE-1:0]    ONE_DATA     = DATA_SIZE'(1);
  localparam logic [CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
  localparam logic [CONTROL_SIZE-1:0] ONE_CONTROL  = CONTROL_SIZE'(1);

  localparam logic [DATA_SIZE-1:0] DATA_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] DATA_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

endpackage

// File: rtl/model_scalar_gradient_step.sv
// Combinational W - eta*dW in signed fixed point, saturating both the step and the result.
module model_scalar_gradient_step
  import model_trainer_pkg::*;
(
  input  logic [DATA_SIZE-1:0] eta,
  input  logic [DATA_SIZE-1:0] grad,
  input  logic [DATA_SIZE-1:0] weight,
  output logic [DATA_SIZE-1:0] weight_next_c
);

  localparam int unsigned PROD_SIZE = 2 * DATA_SIZE;

  logic signed [PROD_SIZE-1:0] product;
  logic signed [PROD_SIZE-1:0] shifted;
  logic        [DATA_SIZE-1:0] step;
  logic signed [DATA_SIZE:0]   diff;
  logic                        step_fits;

  always_comb begin
    product = PROD_SIZE'($signed(eta)) * PROD_SIZE'($signed(grad));
    shifted = product >>> FRACT_SIZE;
    // Step fits when every bit above the data sign bit replicates it.
    step_fits = (shifted[PROD_SIZE-1:DATA_SIZE-1] == '0) ||
                (shifted[PROD_SIZE-1:DATA_SIZE-1] == '1);
    if (step_fits) begin
      step = shifted[DATA_SIZE-1:0];
    end else if (shifted[PROD_SIZE-1]) begin
      step = DATA_MIN;
    end else begin
      step = DATA_MAX;
    end
    diff = (DATA_SIZE+1)'($signed(weight)) - (DATA_SIZE+1)'($signed(step));
    if (diff[DATA_SIZE] == diff[DATA_SIZE-1]) begin
      weight_next_c = diff[DATA_SIZE-1:0];
    end else if (diff[DATA_SIZE]) begin
      weight_next_c = DATA_MIN;
    end else begin
      weight_next_c = DATA_MAX;
    end
  end

endmodule

// File: rtl/model_matrix_controller_update.sv
// Streams a gradient matrix and its weights row-major, emitting saturated updated weights.
module model_matrix_controller_update
  import model_trainer_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] ETA_IN,
  input  logic                 DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] D_IN,
  input  logic [DATA_SIZE-1:0] W_IN,
  output logic                 W_OUT_I_ENABLE,
  output logic                 W_OUT_J_ENABLE,
  output logic [DATA_SIZE-1:0] W_OUT
);

  update_state_t             state;
  logic [CONTROL_SIZE-1:0]   size_i;
  logic [CONTROL_SIZE-1:0]   size_j;
  logic [DATA_SIZE-1:0]      eta;
  logic [CONTROL_SIZE-1:0]   index_i;
  logic [CONTROL_SIZE-1:0]   index_j;
  logic [DATA_SIZE-1:0]      w_next_c;

  model_scalar_gradient_step u_step (
    .eta           (eta),
    .grad          (D_IN),
    .weight        (W_IN),
    .weight_next_c (w_next_c)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= STARTER_STATE;
      size_i         <= ZERO_CONTROL;
      size_j         <= ZERO_CONTROL;
      eta            <= ZERO_DATA;
      index_i        <= ZERO_CONTROL;
      index_j        <= ZERO_CONTROL;
      READY          <= 1'b0;
      W_OUT_I_ENABLE <= 1'b0;
      W_OUT_J_ENABLE <= 1'b0;
      W_OUT          <= ZERO_DATA;
    end else begin
      READY          <= 1'b0;
      W_OUT_I_ENABLE <= 1'b0;
      W_OUT_J_ENABLE <= 1'b0;
      case (state)
        STARTER_STATE: begin
          if (START) begin
            size_i  <= CONTROL_SIZE'(SIZE_I_IN);
            size_j  <= CONTROL_SIZE'(SIZE_J_IN);
            eta     <= ETA_IN;
            index_i <= ZERO_CONTROL;
            index_j <= ZERO_CONTROL;
            // An empty matrix completes immediately without entering the update loop.
            if (SIZE_I_IN == ZERO_DATA || SIZE_J_IN == ZERO_DATA) begin
              READY <= 1'b1;
            end else begin
              state <= UPDATE_STATE;
            end
          end
        end
        UPDATE_STATE: begin
          if (DATA_IN_ENABLE) begin
            W_OUT          <= w_next_c;
            W_OUT_J_ENABLE <= 1'b1;
            W_OUT_I_ENABLE <= (index_j == ZERO_CONTROL);
            if (index_j == size_j - ONE_CONTROL) begin
              index_j <= ZERO_CONTROL;
              if (index_i == size_i - ONE_CONTROL) begin
                index_i <= ZERO_CONTROL;
                READY   <= 1'b1;
                state   <= STARTER_STATE;
              end else begin
                index_i <= index_i + ONE_CONTROL;
              end
            end else begin
              index_j <= index_j + ONE_CONTROL;
            end
          end
        end
        default: state <= STARTER_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_model_matrix_controller_update.sv
// Directed and randomized checks of the matrix weight-update stage against an arithmetic model.
module tb_model_matrix_controller_update;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        READY;
  logic [63:0] SIZE_I_IN;
  logic [63:0] SIZE_J_IN;
  logic [63:0] ETA_IN;
  logic        DATA_IN_ENABLE;
  logic [63:0] D_IN;
  logic [63:0] W_IN;
  logic        W_OUT_I_ENABLE;
  logic        W_OUT_J_ENABLE;
  logic [63:0] W_OUT;

  int          checks;
  int          errors;
  logic [63:0] last_out;

  localparam logic signed [127:0] MAXW = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MINW = -128'sh8000_0000_0000_0000;
  localparam logic [63:0] ONE_FX  = 64'h0000_0001_0000_0000;
  localparam logic [63:0] NEG_ONE = 64'hFFFF_FFFF_0000_0000;

  model_matrix_controller_update dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .READY          (READY),
    .SIZE_I_IN      (SIZE_I_IN),
    .SIZE_J_IN      (SIZE_J_IN),
    .ETA_IN         (ETA_IN),
    .DATA_IN_ENABLE (DATA_IN_ENABLE),
    .D_IN           (D_IN),
    .W_IN           (W_IN),
    .W_OUT_I_ENABLE (W_OUT_I_ENABLE),
    .W_OUT_J_ENABLE (W_OUT_J_ENABLE),
    .W_OUT          (W_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: exact signed arithmetic at 128 bits, clamped to the 64-bit range.
  function automatic logic [63:0] model(input logic [63:0] e, input logic [63:0] d,
                                        input logic [63:0] w);
    logic signed [127:0] p, s, r;
    p = $signed({{64{e[63]}}, e}) * $signed({{64{d[63]}}, d});
    s = p >>> 32;
    if (s > MAXW) s = MAXW;
    else if (s < MINW) s = MINW;
    r = $signed({{64{w[63]}}, w}) - s;
    if (r > MAXW) r = MAXW;
    else if (r < MINW) r = MINW;
    return r[63:0];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_j_en"}, 64'(W_OUT_J_ENABLE), 64'd0);
    check({tag, "_i_en"}, 64'(W_OUT_I_ENABLE), 64'd0);
    check({tag, "_ready"}, 64'(READY), 64'd0);
    check({tag, "_hold"}, W_OUT, last_out);
  endtask

  task automatic do_start(input int si, input int sj, input logic [63:0] e);
    START = 1'b1;
    SIZE_I_IN = 64'(si);
    SIZE_J_IN = 64'(sj);
    ETA_IN = e;
    step();
    START = 1'b0;
    check("start_ready", 64'(READY), 64'((si == 0) || (sj == 0)));
    check("start_j_en", 64'(W_OUT_J_ENABLE), 64'd0);
  endtask

  task automatic strobe_check(input logic [63:0] d, input logic [63:0] w, input logic [63:0] e,
                              input bit exp_i, input bit exp_last);
    logic [63:0] exp;
    D_IN = d;
    W_IN = w;
    DATA_IN_ENABLE = 1'b1;
    exp = model(e, d, w);
    step();
    DATA_IN_ENABLE = 1'b0;
    check("w_out", W_OUT, exp);
    check("j_en", 64'(W_OUT_J_ENABLE), 64'd1);
    check("i_en", 64'(W_OUT_I_ENABLE), 64'(exp_i));
    check("ready", 64'(READY), 64'(exp_last));
    last_out = exp;
  endtask

  task automatic run_matrix(input int si, input int sj, input logic [63:0] e, input int max_gap,
                            input bit rnd, input logic [63:0] d0, input logic [63:0] w0,
                            input int abuse_at);
    logic [63:0] d, w;
    do_start(si, sj, e);
    for (int k = 0; k < si * sj; k++) begin
      int gaps;
      gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gaps; g++) begin
        step();
        check_idle("gap");
      end
      d = rnd ? (($urandom_range(0, 1) == 1) ? rand64() : 64'($signed($urandom))) : d0;
      w = rnd ? rand64() : w0;
      if (k == abuse_at) begin
        START = 1'b1;
        SIZE_I_IN = 64'd9;
        SIZE_J_IN = 64'd9;
        ETA_IN = 64'd0;
      end
      strobe_check(d, w, e, (k % sj) == 0, k == si * sj - 1);
      START = 1'b0;
    end
    step();
    check_idle("post");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_out = '0;
    RST = 1'b0;
    START = 1'b0;
    SIZE_I_IN = '0;
    SIZE_J_IN = '0;
    ETA_IN = '0;
    DATA_IN_ENABLE = 1'b0;
    D_IN = '0;
    W_IN = '0;
    step();
    step();
    check_idle("reset");
    RST = 1'b1;
    step();

    // Basic 2x3: eta 0.5, D 2.0, W 3.0 gives 2.0 everywhere.
    run_matrix(2, 3, 64'h0000_0000_8000_0000, 0, 1'b0, 64'h2_0000_0000, 64'h3_0000_0000, -1);
    check("basic_value", last_out, 64'h2_0000_0000);

    // Gapped db case: eta 1.0, D -1.0, W 0 gives +1.0.
    run_matrix(1, 4, ONE_FX, 3, 1'b0, NEG_ONE, 64'd0, -1);
    check("gap_value", last_out, ONE_FX);

    // Saturation at both rails.
    do_start(1, 2, ONE_FX);
    strobe_check(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, ONE_FX, 1'b1, 1'b0);
    check("sat_hi", W_OUT, 64'h7FFF_FFFF_FFFF_FFFF);
    strobe_check(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, ONE_FX, 1'b0, 1'b1);
    check("sat_lo", W_OUT, 64'h8000_0000_0000_0000);
    step();
    check_idle("sat_post");

    // Zero size: READY next cycle, later strobe produces nothing.
    do_start(3, 0, ONE_FX);
    step();
    check_idle("zero_after");
    DATA_IN_ENABLE = 1'b1;
    D_IN = rand64();
    W_IN = rand64();
    step();
    DATA_IN_ENABLE = 1'b0;
    check_idle("zero_strobe");

    // Strobes in the idle state are ignored.
    DATA_IN_ENABLE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_idle("idle_strobe");
    end
    DATA_IN_ENABLE = 1'b0;

    // START mid-matrix must not change sizes or eta.
    run_matrix(2, 2, 64'h0000_0000_4000_0000, 1, 1'b1, '0, '0, 1);

    // Reset after 3 of 6 elements, then a full clean matrix.
    do_start(2, 3, ONE_FX);
    strobe_check(ONE_FX, 64'h5_0000_0000, ONE_FX, 1'b1, 1'b0);
    strobe_check(ONE_FX, 64'h5_0000_0000, ONE_FX, 1'b0, 1'b0);
    strobe_check(ONE_FX, 64'h5_0000_0000, ONE_FX, 1'b0, 1'b0);
    RST = 1'b0;
    #1;
    last_out = '0;
    check_idle("mid_reset");
    step();
    RST = 1'b1;
    step();
    run_matrix(2, 3, ONE_FX, 1, 1'b0, ONE_FX, 64'h5_0000_0000, -1);
    check("after_reset_value", last_out, 64'h4_0000_0000);

    // Randomized matrices, sizes and gaps.
    for (int t = 0; t < 6; t++) begin
      run_matrix(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                 {32'($signed($urandom_range(0, 3)) - 1), $urandom}, 2, 1'b1, '0, '0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
